de_wb_regfile: RTL and testbench

//  Decode-stage sink for the writeback bus {wr_reg, wregno, regval, wcsrno, wr_csr}, packed MSB->LSB.

---
 rtl/de_wb_regfile_pkg.sv | 33 +++
 rtl/de_pend_counter.sv | 46 ++++
 rtl/de_wb_regfile.sv | 131 +++++++++++++
 tb/tb_de_wb_regfile.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/de_wb_regfile_pkg.sv
// de_wb_regfile_pkg
//   Shared definitions for the decode-stage register file and the writeback
//   bus that feeds it. The WB packer and the DE unpacker both use
//   wb_bus_t, so the field order and widths have only one definition.
//   Bus layout, MSB -> LSB: {wr_reg, wregno, regval, wcsrno, wr_csr}.
package de_wb_regfile_pkg;

    localparam int DBITS        = 32;
    localparam int REGNOBITS    = 5;
    localparam int REGWORDS     = 2 ** REGNOBITS;
    localparam int CSRNOBITS    = 12;
    localparam int CSR_WORDS    = 8;
    localparam int CSR_IDX_BITS = $clog2(CSR_WORDS);
    localparam int PEND_BITS    = 3;
    localparam logic [DBITS-1:0] PASS_VAL = 32'hF0;
    localparam logic [REGNOBITS-1:0] STATUS_REGNO = 5'd10;

    localparam int WB_BUS_BITS = 1 + REGNOBITS + DBITS + CSRNOBITS + 1;

    typedef struct packed {
        logic                 wr_reg;
        logic [REGNOBITS-1:0] wregno;
        logic [DBITS-1:0]     regval;
        logic [CSRNOBITS-1:0] wcsrno;
        logic                 wr_csr;
    } wb_bus_t;

    // True when a bus CSR index selects one of the implemented CSRs.
    function automatic logic csr_in_range(input logic [CSRNOBITS-1:0] no);
        return no < CSRNOBITS'(CSR_WORDS);
    endfunction

endpackage

// File: rtl/de_pend_counter.sv
// de_pend_counter
//   Pending-write counter for one architectural register.
//   inc: an instruction writing this register was issued.
//   dec: a writeback to this register retires.
//   Both at once leave the count unchanged. The count saturates at
//   all-ones; an increment lost to saturation raises ovf for that cycle.
//   A decrement at zero is a WB of an untracked write and is ignored.
// Ports
//   clk, reset   clock, asynchronous active-high reset
//   inc, dec     increment / decrement requests
//   busy         register still has an outstanding writer that the
//                bypass cannot cover this cycle
//   ovf          pulse: increment dropped because the counter is full
module de_pend_counter
    import de_wb_regfile_pkg::*;
#(
    parameter int W = PEND_BITS
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic dec,
    output logic busy,
    output logic ovf
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            case ({inc, dec})
                2'b10: if (cnt != '1) cnt <= cnt + W'(1);
                2'b01: if (cnt != '0) cnt <= cnt - W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // A single outstanding writer that retires this very cycle is served
    // by the WB->read bypass, so it does not need to stall.
    assign busy = (cnt > W'(1)) || ((cnt == W'(1)) && !dec);
    assign ovf  = inc && !dec && (cnt == '1);

endmodule

// File: rtl/de_wb_regfile.sv
// de_wb_regfile
//   Decode-stage sink of the writeback bus. Holds the integer register
//   file and a small CSR file with same-cycle WB->read bypass, tracks
//   outstanding writers per register to produce the RAW-hazard stall,
//   and latches the pass/fail status word written to x10.
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   wb_wr_reg/wregno/regval    WB register write
//   wb_wcsrno/wr_csr           WB CSR write (data shared with regval)
//   de_issue, de_rd            DE issues a register-writing instruction
//   rs1_no, rs2_no, csr_rno    read indices
//   rs1_val, rs2_val, csr_rval combinational read data
//   raw_stall                  a source register has an outstanding writer
//   pend_ovf                   sticky pending-counter saturation flag
//   reg10_val                  sticky status word
module de_wb_regfile
    import de_wb_regfile_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wb_wr_reg,
    input  logic [REGNOBITS-1:0] wb_wregno,
    input  logic [DBITS-1:0]     wb_regval,
    input  logic [CSRNOBITS-1:0] wb_wcsrno,
    input  logic                 wb_wr_csr,
    input  logic                 de_issue,
    input  logic [REGNOBITS-1:0] de_rd,
    input  logic [REGNOBITS-1:0] rs1_no,
    input  logic [REGNOBITS-1:0] rs2_no,
    input  logic [CSRNOBITS-1:0] csr_rno,
    output logic [DBITS-1:0]     rs1_val,
    output logic [DBITS-1:0]     rs2_val,
    output logic [DBITS-1:0]     csr_rval,
    output logic                 raw_stall,
    output logic                 pend_ovf,
    output logic [DBITS-1:0]     reg10_val
);

    wb_bus_t wb;
    assign wb = {wb_wr_reg, wb_wregno, wb_regval, wb_wcsrno, wb_wr_csr};

    logic [DBITS-1:0] rf  [REGWORDS];
    logic [DBITS-1:0] csr [CSR_WORDS];

    logic reg_wr_en;
    logic csr_wr_en;
    assign reg_wr_en = wb.wr_reg && (wb.wregno != '0);
    assign csr_wr_en = wb.wr_csr && csr_in_range(wb.wcsrno);

    // Register file: x0 is never written, and reads of x0 are forced to 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REGWORDS; i++) rf[i] <= '0;
        end else if (reg_wr_en) begin
            rf[wb.wregno] <= wb.regval;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CSR_WORDS; i++) csr[i] <= '0;
        end else if (csr_wr_en) begin
            csr[wb.wcsrno[CSR_IDX_BITS-1:0]] <= wb.regval;
        end
    end

    // Read ports with bypass from the writeback happening this cycle.
    always_comb begin
        rs1_val = rf[rs1_no];
        if (rs1_no == '0)
            rs1_val = '0;
        else if (wb.wr_reg && wb.wregno == rs1_no)
            rs1_val = wb.regval;

        rs2_val = rf[rs2_no];
        if (rs2_no == '0)
            rs2_val = '0;
        else if (wb.wr_reg && wb.wregno == rs2_no)
            rs2_val = wb.regval;

        csr_rval = csr[csr_rno[CSR_IDX_BITS-1:0]];
        if (!csr_in_range(csr_rno))
            csr_rval = '0;
        else if (wb.wr_csr && wb.wcsrno == csr_rno)
            csr_rval = wb.regval;
    end

    // Pending-writer scoreboard, one counter per register except x0.
    logic [REGWORDS-1:0] busy_vec;
    logic [REGWORDS-1:0] ovf_vec;

    assign busy_vec[0] = 1'b0;
    assign ovf_vec[0]  = 1'b0;

    generate
        for (genvar gi = 1; gi < REGWORDS; gi++) begin : g_pend
            logic inc;
            logic dec;
            assign inc = de_issue  && (de_rd     == REGNOBITS'(gi));
            assign dec = wb.wr_reg && (wb.wregno == REGNOBITS'(gi));

            de_pend_counter #(.W(PEND_BITS)) u_cnt (
                .clk   (clk),
                .reset (reset),
                .inc   (inc),
                .dec   (dec),
                .busy  (busy_vec[gi]),
                .ovf   (ovf_vec[gi])
            );
        end
    endgenerate

    assign raw_stall = busy_vec[rs1_no] | busy_vec[rs2_no];

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pend_ovf <= 1'b0;
        else if (|ovf_vec)
            pend_ovf <= 1'b1;
    end

    // Status latch: first PASS_VAL written to x10 sticks until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            reg10_val <= '0;
        else if (wb.wr_reg && wb.wregno == STATUS_REGNO &&
                 wb.regval == PASS_VAL && reg10_val == '0)
            reg10_val <= PASS_VAL;
    end

endmodule

// File: tb/tb_de_wb_regfile.sv
// tb_de_wb_regfile
//   Directed scenarios plus randomized traffic, checked against a
//   behavioural model of the register file, CSR file and scoreboard.
module tb_de_wb_regfile;
    import de_wb_regfile_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 wb_wr_reg;
    logic [REGNOBITS-1:0] wb_wregno;
    logic [DBITS-1:0]     wb_regval;
    logic [CSRNOBITS-1:0] wb_wcsrno;
    logic                 wb_wr_csr;
    logic                 de_issue;
    logic [REGNOBITS-1:0] de_rd;
    logic [REGNOBITS-1:0] rs1_no;
    logic [REGNOBITS-1:0] rs2_no;
    logic [CSRNOBITS-1:0] csr_rno;
    logic [DBITS-1:0]     rs1_val;
    logic [DBITS-1:0]     rs2_val;
    logic [DBITS-1:0]     csr_rval;
    logic                 raw_stall;
    logic                 pend_ovf;
    logic [DBITS-1:0]     reg10_val;

    always #5 clk = ~clk;

    de_wb_regfile dut (
        .clk       (clk),
        .reset     (reset),
        .wb_wr_reg (wb_wr_reg),
        .wb_wregno (wb_wregno),
        .wb_regval (wb_regval),
        .wb_wcsrno (wb_wcsrno),
        .wb_wr_csr (wb_wr_csr),
        .de_issue  (de_issue),
        .de_rd     (de_rd),
        .rs1_no    (rs1_no),
        .rs2_no    (rs2_no),
        .csr_rno   (csr_rno),
        .rs1_val   (rs1_val),
        .rs2_val   (rs2_val),
        .csr_rval  (csr_rval),
        .raw_stall (raw_stall),
        .pend_ovf  (pend_ovf),
        .reg10_val (reg10_val)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_rf  [32];
    logic [31:0] m_csr [8];
    int          m_pend[32];
    bit          m_ovf;
    logic [31:0] m_r10;

    function automatic void model_clear();
        for (int i = 0; i < 32; i++) begin m_rf[i] = 0; m_pend[i] = 0; end
        for (int i = 0; i < 8; i++) m_csr[i] = 0;
        m_ovf = 0;
        m_r10 = 0;
    endfunction

    function automatic logic [31:0] exp_reg(input int no);
        if (no == 0) return 0;
        if (wb_wr_reg && int'(wb_wregno) == no) return wb_regval;
        return m_rf[no];
    endfunction

    function automatic logic [31:0] exp_csr(input int no);
        if (no >= 8) return 0;
        if (wb_wr_csr && int'(wb_wcsrno) == no) return wb_regval;
        return m_csr[no];
    endfunction

    function automatic bit m_busy(input int r);
        bit retiring;
        retiring = wb_wr_reg && int'(wb_wregno) == r;
        return r != 0 && (m_pend[r] > 1 || (m_pend[r] == 1 && !retiring));
    endfunction

    function automatic bit exp_stall();
        return m_busy(int'(rs1_no)) || m_busy(int'(rs2_no));
    endfunction

    // Next state from the inputs currently applied.
    function automatic void model_commit();
        bit inc, dec;
        if (wb_wr_reg && wb_wregno == 10 && wb_regval == 32'hF0 && m_r10 == 0)
            m_r10 = 32'hF0;
        for (int r = 1; r < 32; r++) begin
            inc = de_issue  && int'(de_rd) == r;
            dec = wb_wr_reg && int'(wb_wregno) == r;
            if (inc && !dec) begin
                if (m_pend[r] == 7) m_ovf = 1;
                else m_pend[r]++;
            end else if (dec && !inc && m_pend[r] > 0) begin
                m_pend[r]--;
            end
        end
        if (wb_wr_reg && wb_wregno != 0) m_rf[wb_wregno] = wb_regval;
        if (wb_wr_csr && wb_wcsrno < 8) m_csr[wb_wcsrno] = wb_regval;
    endfunction

    task automatic idle();
        wb_wr_reg = 0; wb_wregno = 0; wb_regval = 0;
        wb_wcsrno = 0; wb_wr_csr = 0;
        de_issue = 0; de_rd = 0;
        rs1_no = 0; rs2_no = 0; csr_rno = 0;
    endtask

    task automatic wb_reg(input int no, input logic [31:0] val);
        wb_wr_reg = 1; wb_wregno = REGNOBITS'(no); wb_regval = val;
    endtask

    // One clock: check all outputs against the model, then advance it.
    task automatic step(input string tag);
        @(negedge clk);
        check({tag, "/rs1"},   rs1_val,   exp_reg(int'(rs1_no)));
        check({tag, "/rs2"},   rs2_val,   exp_reg(int'(rs2_no)));
        check({tag, "/csr"},   csr_rval,  exp_csr(int'(csr_rno)));
        check({tag, "/stall"}, 32'(raw_stall), 32'(exp_stall()));
        check({tag, "/ovf"},   32'(pend_ovf),  32'(m_ovf));
        check({tag, "/r10"},   reg10_val, m_r10);
        $display("cycle %s: rs1[%0d]=%h rs2[%0d]=%h csr[%0h]=%h stall=%0b ovf=%0b r10=%h",
                 tag, rs1_no, rs1_val, rs2_no, rs2_val, csr_rno, csr_rval,
                 raw_stall, pend_ovf, reg10_val);
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset(input string tag);
        #2 reset = 1;
        #1;
        model_clear();
        check({tag, "/stall"}, 32'(raw_stall), 32'(exp_stall()));
        check({tag, "/ovf"},   32'(pend_ovf),  32'h0);
        check({tag, "/r10"},   reg10_val,      32'h0);
        @(posedge clk);
        #2 reset = 0;
    endtask

    initial begin
        model_clear();
        idle();
        reset = 1;
        #2;
        check("reset/rs1",   rs1_val,   32'h0);
        check("reset/stall", 32'(raw_stall), 32'h0);
        check("reset/ovf",   32'(pend_ovf),  32'h0);
        check("reset/r10",   reg10_val, 32'h0);
        @(negedge clk);
        reset = 0;
        @(posedge clk);
        #1;

        // 1: bypass then registered value
        idle(); wb_reg(5, 32'hDEADBEEF); rs1_no = 5;
        #1 check("t1/bypass", rs1_val, 32'hDEADBEEF);
        step("t1a");
        idle(); rs1_no = 5;
        #1 check("t1/held", rs1_val, 32'hDEADBEEF);
        step("t1b");

        // 2: x0 is never stored
        idle(); wb_reg(0, 32'h1234); rs1_no = 0;
        #1 check("t2/x0_now", rs1_val, 32'h0);
        step("t2a");
        idle(); rs1_no = 0;
        #1 check("t2/x0_later", rs1_val, 32'h0);
        step("t2b");

        // 3: two writers of x7
        idle(); de_issue = 1; de_rd = 7; step("t3_iss1");
        idle(); de_issue = 1; de_rd = 7; step("t3_iss2");
        idle(); rs2_no = 7;
        #1 check("t3/stall_pend2", 32'(raw_stall), 32'h1);
        step("t3_wait");
        idle(); rs2_no = 7; wb_reg(7, 32'h77);
        #1 check("t3/stall_wb1", 32'(raw_stall), 32'h1);
        step("t3_wb1");
        idle(); rs2_no = 7; wb_reg(7, 32'h78);
        #1 check("t3/stall_wb2", 32'(raw_stall), 32'h0);
        step("t3_wb2");
        idle(); rs2_no = 7;
        #1 check("t3/stall_after", 32'(raw_stall), 32'h0);
        step("t3_after");

        // 4: issue and retire x3 in the same cycle with one writer pending
        idle(); de_issue = 1; de_rd = 3; step("t4_iss");
        idle(); de_issue = 1; de_rd = 3; wb_reg(3, 32'h33); rs1_no = 3; step("t4_both");
        idle(); rs1_no = 3;
        #1 check("t4/stall_pend1", 32'(raw_stall), 32'h1);
        step("t4_chk");
        idle(); wb_reg(3, 32'h34); step("t4_drain");

        // 5: status latch
        idle(); wb_reg(10, 32'hF0); step("t5_pass");
        check("t5/r10_set", reg10_val, 32'hF0);
        idle(); wb_reg(10, 32'h0F); step("t5_other");
        check("t5/r10_hold", reg10_val, 32'hF0);

        // 6: CSR writes, in and out of range
        idle(); wb_wr_csr = 1; wb_wcsrno = 12'd2; wb_regval = 32'hA5; step("t6_w2");
        idle(); wb_wr_csr = 1; wb_wcsrno = 12'h300; wb_regval = 32'h1; step("t6_w300");
        idle(); csr_rno = 12'd2;
        #1 check("t6/csr2", csr_rval, 32'hA5);
        step("t6_r2");
        idle(); csr_rno = 12'h300;
        #1 check("t6/csr300", csr_rval, 32'h0);
        step("t6_r300");

        // Saturation: eight issues to x20 with no writeback
        for (int i = 0; i < 8; i++) begin
            idle(); de_issue = 1; de_rd = 20; step("ovf_iss");
        end
        check("ovf/set", 32'(pend_ovf), 32'h1);

        // Reset in the middle of a stall
        idle(); de_issue = 1; de_rd = 9; step("rst_iss");
        idle(); rs1_no = 9;
        #1 check("rst/stall_before", 32'(raw_stall), 32'h1);
        pulse_reset("rst_mid");
        check("rst/stall_after", 32'(raw_stall), 32'h0);
        step("rst_post");

        // Randomized traffic on a small register window to provoke hazards
        for (int n = 0; n < 400; n++) begin
            idle();
            if ($urandom_range(1, 0) == 1) wb_reg($urandom_range(11, 0), $urandom);
            if ($urandom_range(3, 0) == 0) begin
                wb_wr_csr = 1;
                wb_wcsrno = ($urandom_range(4, 0) == 0) ? 12'h300 : CSRNOBITS'($urandom_range(9, 0));
                if (!wb_wr_reg) wb_regval = $urandom;
            end
            if ($urandom_range(7, 0) == 0) begin
                wb_wr_reg = 1; wb_wregno = 10; wb_regval = 32'hF0;
            end
            rs1_no  = REGNOBITS'($urandom_range(11, 0));
            rs2_no  = REGNOBITS'($urandom_range(11, 0));
            csr_rno = CSRNOBITS'($urandom_range(9, 0));
            de_rd   = REGNOBITS'($urandom_range(11, 0));
            de_issue = ($urandom_range(9, 0) < 5) && !exp_stall();
            step("rnd");
            if (n == 250) pulse_reset("rnd_rst");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
